// File: rtl/fixed_bcd_display_ctrl.sv
// Converts a signed fixed-point result into sign + integer/fraction BCD digits by
// driving two external BCD engines in parallel. Optional macro: LEADING_ZERO_BLANK_EN.
module fixed_bcd_display_ctrl #(
  parameter int INT_BITS       = 16,
  parameter int FRAC_BITS      = 8,
  parameter int INT_DIGITS     = 5,
  parameter int FRAC_DIGITS    = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_L,
  input  logic                       i_Start,
  input  logic [INT_BITS+FRAC_BITS-1:0] i_Value,
  output logic                       o_Busy,
  output logic                       o_Int_Start,
  output logic [INT_BITS-1:0]        o_Int_Binary,
  input  logic [INT_DIGITS*4-1:0]    i_Int_BCD,
  input  logic                       i_Int_DV,
  output logic                       o_Frac_Start,
  output logic [FRAC_BITS-1:0]       o_Frac_Binary,
  input  logic [FRAC_DIGITS*4-1:0]   i_Frac_BCD,
  input  logic                       i_Frac_DV,
  output logic                       o_Sign,
  output logic [INT_DIGITS*4-1:0]    o_Int_Digits,
  output logic [FRAC_DIGITS*4-1:0]   o_Frac_Digits,
  output logic                       o_DV,
  output logic                       o_Err
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE, ERR} state_t;

  state_t state, state_next;

  logic [W-1:0]             magnitude;
  logic                     sign_pend;
  logic                     int_done, frac_done;
  logic [CW-1:0]            tmo_count;
  logic [INT_DIGITS*4-1:0]  int_cap, int_raw, int_shown;
  logic [FRAC_DIGITS*4-1:0] frac_cap, frac_raw;
  logic                     accept, cap_int, cap_frac;

  assign magnitude = i_Value[W-1] ? -i_Value : i_Value;
  assign o_Busy    = (state != IDLE);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_next;
  end

  // The counter is zero only in the first CONV cycle, which doubles as the
  // stale-DV mask for engines still holding DV from a previous run.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cap_int    = 1'b0;
    cap_frac   = 1'b0;
    case (state)
      IDLE: begin
        if (i_Start) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        cap_int  = i_Int_DV  && !int_done  && (tmo_count != '0);
        cap_frac = i_Frac_DV && !frac_done && (tmo_count != '0);
        if ((int_done || cap_int) && (frac_done || cap_frac))
          state_next = DONE;
        else if (tmo_count == CW'(TIMEOUT_CYCLES - 1))
          state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign int_raw  = cap_int  ? i_Int_BCD  : int_cap;
  assign frac_raw = cap_frac ? i_Frac_BCD : frac_cap;

`ifdef LEADING_ZERO_BLANK_EN
  logic leading;
  always_comb begin
    int_shown = int_raw;
    leading   = 1'b1;
    for (int d = INT_DIGITS - 1; d > 0; d--) begin
      if (leading && int_raw[d*4 +: 4] == 4'd0) int_shown[d*4 +: 4] = 4'hF;
      else                                      leading = 1'b0;
    end
  end
`else
  always_comb begin
    int_shown = int_raw;
  end
`endif

  // Digits are loaded on the edge entering DONE so o_DV coincides with the DONE cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Int_Start   <= 1'b0;
      o_Frac_Start  <= 1'b0;
      o_Int_Binary  <= '0;
      o_Frac_Binary <= '0;
      o_Sign        <= 1'b0;
      o_Int_Digits  <= '0;
      o_Frac_Digits <= '0;
      o_DV          <= 1'b0;
      o_Err         <= 1'b0;
      sign_pend     <= 1'b0;
      int_done      <= 1'b0;
      frac_done     <= 1'b0;
      tmo_count     <= '0;
      int_cap       <= '0;
      frac_cap      <= '0;
    end else begin
      o_DV  <= 1'b0;
      o_Err <= 1'b0;
      if (accept) begin
        o_Int_Binary  <= magnitude[W-1:FRAC_BITS];
        o_Frac_Binary <= magnitude[FRAC_BITS-1:0];
        sign_pend     <= i_Value[W-1] && (magnitude != '0);
        int_done      <= 1'b0;
        frac_done     <= 1'b0;
        tmo_count     <= '0;
        o_Int_Start   <= 1'b1;
        o_Frac_Start  <= 1'b1;
      end
      if (state == CONV) begin
        tmo_count <= tmo_count + CW'(1);
        if (cap_int) begin
          int_cap     <= i_Int_BCD;
          int_done    <= 1'b1;
          o_Int_Start <= 1'b0;
        end
        if (cap_frac) begin
          frac_cap     <= i_Frac_BCD;
          frac_done    <= 1'b1;
          o_Frac_Start <= 1'b0;
        end
        if (state_next == DONE) begin
          o_Sign        <= sign_pend;
          o_Int_Digits  <= int_shown;
          o_Frac_Digits <= frac_raw;
          o_DV          <= 1'b1;
        end
        if (state_next == ERR) begin
          o_Int_Start  <= 1'b0;
          o_Frac_Start <= 1'b0;
          o_Err        <= 1'b1;
        end
      end
    end
  end

endmodule
